// File: rtl/counter_wrap_pkg.sv
// Shared types and helpers for the thresholded wrap counter sequencer.
package counter_wrap_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCount = 2'd1,
        StOver  = 2'd2,
        StClear = 2'd3
    } state_e;

    localparam int unsigned DefaultWidth     = 4;
    localparam int unsigned DefaultThreshold = 8;
    localparam int unsigned DefaultWrapsW    = 8;
    localparam int unsigned MaxWidth         = 16;

    // Result of one accepted step
    typedef struct packed {
        logic [MaxWidth-1:0] count;  // next counter value
        logic                over;   // next value exceeds threshold
        logic                clear;  // full-scale wrap straight to the clear cycle
    } step_res_t;

    // Next count for an accepted step. Operands are zero-extended to MaxWidth;
    // width selects the live bits. At full-scale threshold the counter can never
    // exceed it, so the top value wraps directly into the clear cycle.
    function automatic step_res_t next_count(input logic [MaxWidth-1:0] cnt,
                                             input logic [MaxWidth-1:0] thr,
                                             input int unsigned         width);
        step_res_t         res;
        logic [MaxWidth:0] max_val;
        logic [MaxWidth:0] nxt;
        res     = '0;
        max_val = (17'd1 << width) - 17'd1;
        nxt     = '0;
        if ((thr == max_val[MaxWidth-1:0]) && (cnt == max_val[MaxWidth-1:0])) begin
            res.count = '0;
            res.clear = 1'b1;
        end else begin
            nxt       = ({1'b0, cnt} + 17'd1) & max_val;
            res.count = nxt[MaxWidth-1:0];
            res.over  = (nxt[MaxWidth-1:0] > thr);
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_wrap_ctrl.sv
// Thresholded up-counter sequencer: counts accepted steps, flags one OVER
// cycle when the count exceeds the threshold, then forces one CLEAR cycle at 0.
// Threshold writes outside IDLE are deferred to the next CLEAR or IDLE cycle.
// Optional: define COUNTER_WRAP_CTRL_ASSERT_EN to embed protocol assertions.
module counter_wrap_ctrl
    import counter_wrap_pkg::*;
#(
    parameter int unsigned WIDTH             = DefaultWidth,
    parameter int unsigned DEFAULT_THRESHOLD = DefaultThreshold,
    parameter int unsigned WRAPS_W           = DefaultWrapsW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               step_valid,
    output logic               step_ready,
    input  logic               thr_we,
    input  logic [WIDTH-1:0]   thr_in,
    output logic [WIDTH-1:0]   threshold,
    output logic [WIDTH-1:0]   counter,
    output logic               over,
    output logic               wrap_pulse,
    output logic [WRAPS_W-1:0] wraps
);

    localparam logic [WIDTH-1:0] ThrReset = WIDTH'(DEFAULT_THRESHOLD);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   counter_q, counter_d;
    logic [WIDTH-1:0]   thr_q, thr_d;
    logic [WIDTH-1:0]   pend_thr_q, pend_thr_d;
    logic               pend_flag_q, pend_flag_d;
    logic [WRAPS_W-1:0] wraps_q, wraps_d;
    step_res_t          step;

    // State register with immediate asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            counter_q   <= '0;
            thr_q       <= ThrReset;
            pend_thr_q  <= ThrReset;
            pend_flag_q <= 1'b0;
            wraps_q     <= '0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            thr_q       <= thr_d;
            pend_thr_q  <= pend_thr_d;
            pend_flag_q <= pend_flag_d;
            wraps_q     <= wraps_d;
        end
    end

    // Next-state, count and threshold update logic
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        thr_d       = thr_q;
        pend_thr_d  = pend_thr_q;
        pend_flag_d = pend_flag_q;
        wraps_d     = wraps_q;
        step        = next_count(MaxWidth'(counter_q), MaxWidth'(thr_q), WIDTH);

        unique case (state_q)
            StIdle: begin
                // A direct write beats any stale pending value
                if (thr_we) begin
                    thr_d       = thr_in;
                    pend_flag_d = 1'b0;
                end else if (pend_flag_q) begin
                    thr_d       = pend_thr_q;
                    pend_flag_d = 1'b0;
                end
                if (enable) begin
                    state_d = StCount;
                end
            end
            StCount: begin
                // Dropping enable wins over a simultaneous step
                if (!enable) begin
                    state_d = StIdle;
                end else if (step_valid) begin
                    counter_d = step.count[WIDTH-1:0];
                    if (step.clear) begin
                        state_d = StClear;
                    end else if (step.over) begin
                        state_d = StOver;
                    end
                end
            end
            StOver: begin
                counter_d = '0;
                state_d   = StClear;
            end
            StClear: begin
                counter_d = '0;
                if (pend_flag_q) begin
                    thr_d = pend_thr_q;
                end
                pend_flag_d = 1'b0;
                if (wraps_q != {WRAPS_W{1'b1}}) begin
                    wraps_d = wraps_q + WRAPS_W'(1);
                end
                state_d = enable ? StCount : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Writes outside IDLE are parked; placed last so a write in CLEAR
        // survives the flag clear above and lands at the next IDLE or CLEAR
        if (thr_we && (state_q != StIdle)) begin
            pend_thr_d  = thr_in;
            pend_flag_d = 1'b1;
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        step_ready = (state_q == StCount);
        over       = (state_q == StOver);
        wrap_pulse = (state_q == StClear);
        counter    = counter_q;
        threshold  = thr_q;
        wraps      = wraps_q;
    end

`ifdef COUNTER_WRAP_CTRL_ASSERT_EN
    a_over_clears: assert property (
        @(posedge clk) disable iff (rst)
        (counter > threshold) |-> ##1 (counter == '0) ##1 (counter == '0)
    ) else $error("counter_wrap_ctrl: count not cleared after over, state %s", state_q.name());

    a_onehot_out: assert property (
        @(posedge clk) disable iff (rst)
        $onehot0({wrap_pulse, over, step_ready})
    ) else $error("counter_wrap_ctrl: decoded outputs not one-hot, state %s", state_q.name());

    a_wrap_single: assert property (
        @(posedge clk) disable iff (rst)
        wrap_pulse |=> !wrap_pulse
    ) else $error("counter_wrap_ctrl: wrap_pulse longer than one cycle, state %s",
                  state_q.name());
`endif

endmodule
